// File: rtl/buster_mem_test_engine.sv
// -----------------------------------------------------------------------------
// buster_mem_test_engine
//
// Self-checking memory traffic generator for the Buster bus master side
// (upstream of the MIG UI bridge). On start it writes Pattern(a) =
// DATA_BASE + a to NUM_WORDS consecutive 128-bit words. It then reads the
// words back and checks the in-order responses. It reports pass/fail, the
// first failing address and data, and the write-phase and read-phase cycle
// counts.
//
// Ports:
//   clk_100                clock
//   reset_n                synchronous, active-low reset
//   start                  level; sampled only while idle or done
//   busy                   high while a test is running
//   done                   high once a test has finished; held until next start
//   pass                   test result, valid while done=1
//   fail_addr              address of first mismatch (all ones = protocol error)
//   fail_data              read data of first mismatch
//   write_cycles           write-phase cycle count (saturating)
//   read_cycles            read-phase cycle count (saturating)
//   bus_enable             request valid
//   bus_addr               request word address
//   bus_write              1 = write, 0 = read
//   bus_write_data         write data
//   bus_write_byte_enable  16'hffff while writing, else 0
//   bus_ready              request accepted when bus_enable & bus_ready
//   bus_read_data          read response data
//   bus_read_data_valid    in-order read response strobe
// -----------------------------------------------------------------------------
module buster_mem_test_engine #(
  parameter int unsigned     ADDR_WIDTH = 24,
  parameter longint unsigned NUM_WORDS  = 64'h1000000,
  parameter logic [127:0]    DATA_BASE  = 128'hdeadbeefabad1deaba53b411fadebabe
) (
  input  logic                  clk_100,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [127:0]          fail_data,
  output logic [63:0]           write_cycles,
  output logic [63:0]           read_cycles,
  output logic                  bus_enable,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write,
  output logic [127:0]          bus_write_data,
  output logic [15:0]           bus_write_byte_enable,
  input  logic                  bus_ready,
  input  logic [127:0]          bus_read_data,
  input  logic                  bus_read_data_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(64'd1);
  localparam logic [ADDR_WIDTH:0]   OUTS_ONE  = (ADDR_WIDTH + 1)'(64'd1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ      = 3'd2,
    S_READ_WAIT = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [127:0]          fail_data_q;
  logic [63:0]           write_cycles_q;
  logic [63:0]           read_cycles_q;
  logic                  bus_enable_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  bus_write_q;
  logic [127:0]          wdata_q;
  logic [15:0]           be_q;
  logic [ADDR_WIDTH-1:0] chk_q;
  logic [ADDR_WIDTH:0]   outstanding_q;
  logic [ADDR_WIDTH:0]   outstanding_d;

  logic accept_s;
  logic read_accept_s;
  logic resp_s;

  // Address-derived test pattern, wrapping mod 2^128.
  function automatic logic [127:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    pattern = DATA_BASE + 128'(a);
  endfunction

  // Saturating cycle-counter increment.
  function automatic logic [63:0] sat_inc(input logic [63:0] c);
    sat_inc = (c == {64{1'b1}}) ? c : c + 64'd1;
  endfunction

  assign accept_s      = bus_enable_q & bus_ready;
  assign read_accept_s = accept_s & ~bus_write_q;
  // Only responses that match an issued read retire one.
  assign resp_s        = bus_read_data_valid & (outstanding_q != '0);

  // Outstanding-read tracking; a same-cycle issue and retire cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (read_accept_s && !resp_s) begin
      outstanding_d = outstanding_q + OUTS_ONE;
    end else if (!read_accept_s && resp_s) begin
      outstanding_d = outstanding_q - OUTS_ONE;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Main controller: sequencing, request generation, checking and counters.
  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_addr_q    <= '0;
      fail_data_q    <= 128'd0;
      write_cycles_q <= 64'd0;
      read_cycles_q  <= 64'd0;
      bus_enable_q   <= 1'b0;
      addr_q         <= '0;
      bus_write_q    <= 1'b0;
      wdata_q        <= 128'd0;
      be_q           <= 16'h0000;
      chk_q          <= '0;
      outstanding_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_WRITE;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_addr_q    <= '0;
            fail_data_q    <= 128'd0;
            write_cycles_q <= 64'd0;
            read_cycles_q  <= 64'd0;
            bus_enable_q   <= 1'b1;
            addr_q         <= '0;
            bus_write_q    <= 1'b1;
            wdata_q        <= pattern('0);
            be_q           <= 16'hffff;
            chk_q          <= '0;
            outstanding_q  <= '0;
          end else begin
            state_q <= state_q;
          end
        end

        S_WRITE: begin
          write_cycles_q <= sat_inc(write_cycles_q);
          if (bus_read_data_valid) begin
            // No read has been issued yet, so any response is spurious.
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_addr_q  <= '1;
            bus_enable_q <= 1'b0;
            bus_write_q  <= 1'b0;
            be_q         <= 16'h0000;
            wdata_q      <= 128'd0;
          end else if (accept_s) begin
            if (addr_q == LAST_ADDR) begin
              // Straight into reads with no idle cycle; enable stays high.
              state_q     <= S_READ;
              addr_q      <= '0;
              bus_write_q <= 1'b0;
              be_q        <= 16'h0000;
              wdata_q     <= 128'd0;
            end else begin
              addr_q  <= addr_q + ADDR_ONE;
              wdata_q <= pattern(addr_q + ADDR_ONE);
            end
          end else begin
            // Stalled: request fields hold.
            addr_q <= addr_q;
          end
        end

        S_READ, S_READ_WAIT: begin
          read_cycles_q <= sat_inc(read_cycles_q);
          outstanding_q <= outstanding_d;
          if ((state_q == S_READ) && accept_s) begin
            if (addr_q == LAST_ADDR) begin
              state_q      <= S_READ_WAIT;
              bus_enable_q <= 1'b0;
              addr_q       <= '0;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
            end
          end else begin
            addr_q <= addr_q;
          end
          // Checker results take priority over the issue-side transition.
          if (bus_read_data_valid) begin
            if (outstanding_q == '0) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= 1'b0;
              fail_addr_q  <= '1;
              bus_enable_q <= 1'b0;
            end else if (bus_read_data == pattern(chk_q)) begin
              if (chk_q == LAST_ADDR) begin
                state_q      <= S_DONE;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                pass_q       <= 1'b1;
                bus_enable_q <= 1'b0;
              end else begin
                chk_q <= chk_q + ADDR_ONE;
              end
            end else begin
              state_q      <= S_DRAIN;
              pass_q       <= 1'b0;
              fail_addr_q  <= chk_q;
              fail_data_q  <= bus_read_data;
              bus_enable_q <= 1'b0;
            end
          end else begin
            chk_q <= chk_q;
          end
        end

        S_DRAIN: begin
          // Discard late responses so the bridge is empty before DONE.
          outstanding_q <= outstanding_d;
          if (outstanding_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end else begin
            state_q <= S_DRAIN;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          bus_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign pass                  = pass_q;
  assign fail_addr             = fail_addr_q;
  assign fail_data             = fail_data_q;
  assign write_cycles          = write_cycles_q;
  assign read_cycles           = read_cycles_q;
  assign bus_enable            = bus_enable_q;
  assign bus_addr              = addr_q;
  assign bus_write             = bus_write_q;
  assign bus_write_data        = wdata_q;
  assign bus_write_byte_enable = be_q;

endmodule

// File: tb/tb_buster_mem_test_engine.sv
module tb_buster_mem_test_engine;

  localparam logic [127:0] BASE = 128'hdeadbeefabad1deaba53b411fadebabe;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic reset_n;
  logic start_a;
  logic start_b;
  logic stall_en;
  logic corrupt_en;

  int checks = 0;
  int errors = 0;

  // Instance A: NUM_WORDS = 4
  logic         a_busy, a_done, a_pass, a_en, a_wr, ready_a, rv_a;
  logic [23:0]  a_fail_addr, a_addr;
  logic [127:0] a_fail_data, a_wdata, rdata_a;
  logic [63:0]  a_wcyc, a_rcyc;
  logic [15:0]  a_be;

  // Instance B: NUM_WORDS = 1
  logic         b_busy, b_done, b_pass, b_en, b_wr, ready_b, rv_b;
  logic [23:0]  b_fail_addr, b_addr;
  logic [127:0] b_fail_data, b_wdata, rdata_b;
  logic [63:0]  b_wcyc, b_rcyc;
  logic [15:0]  b_be;

  buster_mem_test_engine #(.ADDR_WIDTH(24), .NUM_WORDS(64'd4), .DATA_BASE(BASE)) dut_a (
    .clk_100(clk_100), .reset_n(reset_n), .start(start_a),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail_addr(a_fail_addr), .fail_data(a_fail_data),
    .write_cycles(a_wcyc), .read_cycles(a_rcyc),
    .bus_enable(a_en), .bus_addr(a_addr), .bus_write(a_wr),
    .bus_write_data(a_wdata), .bus_write_byte_enable(a_be),
    .bus_ready(ready_a), .bus_read_data(rdata_a), .bus_read_data_valid(rv_a)
  );

  buster_mem_test_engine #(.ADDR_WIDTH(24), .NUM_WORDS(64'd1), .DATA_BASE(BASE)) dut_b (
    .clk_100(clk_100), .reset_n(reset_n), .start(start_b),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail_addr(b_fail_addr), .fail_data(b_fail_data),
    .write_cycles(b_wcyc), .read_cycles(b_rcyc),
    .bus_enable(b_en), .bus_addr(b_addr), .bus_write(b_wr),
    .bus_write_data(b_wdata), .bus_write_byte_enable(b_be),
    .bus_ready(ready_b), .bus_read_data(rdata_b), .bus_read_data_valid(rv_b)
  );

  // Slave A: stalls 2 cycles on write addr 1 and read addr 2 when enabled;
  // read latency 3 cycles after the accept cycle.
  int          stall_cnt = 0;
  int          resp_total_a = 0;
  logic        stall_hit_a;
  logic        s1_v, s2_v;
  logic [23:0] s1_addr, s2_addr;

  assign stall_hit_a = a_wr ? (a_addr == 24'd1) : (a_addr == 24'd2);
  assign ready_a = !(stall_en && a_en && stall_hit_a && (stall_cnt < 2));

  always @(posedge clk_100) begin
    if (a_en && !ready_a) stall_cnt <= stall_cnt + 1;
    else if (a_en && ready_a) stall_cnt <= 0;
    if (!reset_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; rv_a <= 1'b0;
      s1_addr <= 24'd0; s2_addr <= 24'd0; rdata_a <= 128'd0;
    end else begin
      s1_v    <= a_en && ready_a && !a_wr;
      s1_addr <= a_addr;
      s2_v    <= s1_v;
      s2_addr <= s1_addr;
      rv_a    <= s2_v;
      rdata_a <= s2_v ? ((BASE + {104'd0, s2_addr}) ^ {127'd0, corrupt_en && (s2_addr == 24'd2)}) : 128'd0;
      if (s2_v) resp_total_a <= resp_total_a + 1;
    end
  end

  // Slave B: always ready, same latency.
  logic        t1_v, t2_v;
  logic [23:0] t1_addr, t2_addr;
  assign ready_b = 1'b1;

  always @(posedge clk_100) begin
    if (!reset_n) begin
      t1_v <= 1'b0; t2_v <= 1'b0; rv_b <= 1'b0;
      t1_addr <= 24'd0; t2_addr <= 24'd0; rdata_b <= 128'd0;
    end else begin
      t1_v    <= b_en && ready_b && !b_wr;
      t1_addr <= b_addr;
      t2_v    <= t1_v;
      t2_addr <= t1_addr;
      rv_b    <= t2_v;
      rdata_b <= t2_v ? (BASE + {104'd0, t2_addr}) : 128'd0;
    end
  end

  // Bus monitor state (touched only by the stimulus process)
  logic [23:0]  wr_exp_a = 24'd0, rd_exp_a = 24'd0;
  int           wr_cnt_a = 0, rd_cnt_a = 0, stall_seen = 0;
  int           wr_cnt_b = 0, rd_cnt_b = 0;
  logic         prev_stall = 1'b0;
  logic [23:0]  held_addr;
  logic [127:0] held_data;
  logic         held_wr;
  logic [15:0]  held_be;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the bus traffic of the current cycle, then advance one clock.
  task automatic step();
    if (a_en !== 1'b1) begin
      wr_exp_a = 24'd0;
      rd_exp_a = 24'd0;
      prev_stall = 1'b0;
    end else if (ready_a) begin
      if (a_wr) begin
        chk("a_wr_addr", 128'(a_addr), 128'(wr_exp_a));
        chk("a_wr_data", a_wdata, BASE + 128'(wr_exp_a));
        chk("a_wr_be", 128'(a_be), 128'(16'hffff));
        wr_exp_a = wr_exp_a + 24'd1;
        wr_cnt_a++;
      end else begin
        chk("a_rd_addr", 128'(a_addr), 128'(rd_exp_a));
        rd_exp_a = rd_exp_a + 24'd1;
        rd_cnt_a++;
      end
      prev_stall = 1'b0;
    end else begin
      stall_seen++;
      if (prev_stall) begin
        chk("stall_addr", 128'(a_addr), 128'(held_addr));
        chk("stall_data", a_wdata, held_data);
        chk("stall_wr", 128'(a_wr), 128'(held_wr));
        chk("stall_be", 128'(a_be), 128'(held_be));
      end
      held_addr = a_addr; held_data = a_wdata; held_wr = a_wr; held_be = a_be;
      prev_stall = 1'b1;
    end
    if (b_en === 1'b1) begin
      chk("b_addr", 128'(b_addr), 128'd0);
      if (b_wr) begin
        chk("b_wr_data", b_wdata, BASE);
        wr_cnt_b++;
      end else begin
        rd_cnt_b++;
      end
    end
    @(posedge clk_100);
    #1;
  endtask

  task automatic run_a(input string tag);
    int n = 0;
    while (!a_done && n < 300) begin step(); n++; end
    chk({tag, "_done"}, 128'(a_done), 128'd1);
  endtask

  task automatic run_b(input string tag);
    int n = 0;
    while (!b_done && n < 300) begin step(); n++; end
    chk({tag, "_done"}, 128'(b_done), 128'd1);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wr_cnt_a = 0;
    rd_cnt_a = 0;
    stall_seen = 0;
  endtask

  initial begin
    int n;
    int resp_before;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    stall_en = 1'b0; corrupt_en = 1'b0;
    step(); step(); step();

    // Reset state
    chk("rst_en", 128'(a_en), 128'd0);
    chk("rst_busy", 128'(a_busy), 128'd0);
    chk("rst_done", 128'(a_done), 128'd0);
    chk("rst_pass", 128'(a_pass), 128'd0);
    chk("rst_wcyc", 128'(a_wcyc), 128'd0);
    chk("rst_rcyc", 128'(a_rcyc), 128'd0);
    chk("rst_faddr", 128'(a_fail_addr), 128'd0);
    chk("rst_fdata", a_fail_data, 128'd0);
    chk("rst_be", 128'(a_be), 128'd0);
    chk("rst_wr", 128'(a_wr), 128'd0);
    reset_n = 1'b1;
    step();

    // Test 1: ideal slave
    pulse_start_a();
    chk("t1_start_en", 128'(a_en), 128'd1);
    chk("t1_start_wr", 128'(a_wr), 128'd1);
    chk("t1_start_busy", 128'(a_busy), 128'd1);
    run_a("t1");
    chk("t1_pass", 128'(a_pass), 128'd1);
    chk("t1_busy", 128'(a_busy), 128'd0);
    chk("t1_wcyc", 128'(a_wcyc), 128'd4);
    chk("t1_rcyc", 128'(a_rcyc), 128'd7);
    chk("t1_writes", 128'(wr_cnt_a), 128'd4);
    chk("t1_reads", 128'(rd_cnt_a), 128'd4);
    step();
    chk("t1_hold_done", 128'(a_done), 128'd1);

    // Test 2: two-cycle stalls on write addr 1 and read addr 2
    stall_en = 1'b1;
    pulse_start_a();
    run_a("t2");
    stall_en = 1'b0;
    chk("t2_pass", 128'(a_pass), 128'd1);
    chk("t2_wcyc", 128'(a_wcyc), 128'd6);
    chk("t2_rcyc", 128'(a_rcyc), 128'd9);
    chk("t2_stalls", 128'(stall_seen), 128'd4);
    chk("t2_writes", 128'(wr_cnt_a), 128'd4);

    // Test 3: corrupted response for addr 2
    corrupt_en = 1'b1;
    resp_before = resp_total_a;
    pulse_start_a();
    run_a("t3");
    corrupt_en = 1'b0;
    chk("t3_pass", 128'(a_pass), 128'd0);
    chk("t3_faddr", 128'(a_fail_addr), 128'd2);
    chk("t3_fdata", a_fail_data, (BASE + 128'd2) ^ 128'd1);
    chk("t3_drained", 128'({s1_v, s2_v, rv_a}), 128'd0);
    chk("t3_resps", 128'(resp_total_a - resp_before), 128'd4);
    chk("t3_wcyc", 128'(a_wcyc), 128'd4);
    chk("t3_rcyc", 128'(a_rcyc), 128'd6);
    chk("t3_busy", 128'(a_busy), 128'd0);

    // Test 6: restart from DONE after the failing run
    pulse_start_a();
    chk("t6_clr_done", 128'(a_done), 128'd0);
    chk("t6_clr_pass", 128'(a_pass), 128'd0);
    chk("t6_clr_faddr", 128'(a_fail_addr), 128'd0);
    chk("t6_clr_fdata", a_fail_data, 128'd0);
    chk("t6_clr_wcyc", 128'(a_wcyc), 128'd0);
    chk("t6_clr_rcyc", 128'(a_rcyc), 128'd0);
    chk("t6_addr0", 128'(a_addr), 128'd0);
    run_a("t6");
    chk("t6_pass", 128'(a_pass), 128'd1);
    chk("t6_wcyc", 128'(a_wcyc), 128'd4);
    chk("t6_rcyc", 128'(a_rcyc), 128'd7);

    // Test 4: NUM_WORDS = 1
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("t4_en", 128'(b_en), 128'd1);
    chk("t4_wr", 128'(b_wr), 128'd1);
    chk("t4_be", 128'(b_be), 128'(16'hffff));
    step();
    chk("t4_nogap_en", 128'(b_en), 128'd1);
    chk("t4_nogap_rd", 128'(b_wr), 128'd0);
    chk("t4_nogap_addr", 128'(b_addr), 128'd0);
    run_b("t4");
    chk("t4_pass", 128'(b_pass), 128'd1);
    chk("t4_wcyc", 128'(b_wcyc), 128'd1);
    chk("t4_rcyc", 128'(b_rcyc), 128'd4);
    chk("t4_writes", 128'(wr_cnt_b), 128'd1);
    chk("t4_reads", 128'(rd_cnt_b), 128'd1);

    // Test 5: start held during WRITE, then reset at the write to addr 2
    step();
    start_a = 1'b1;
    step();
    wr_cnt_a = 0;
    n = 0;
    while (!(a_en && a_wr && (a_addr == 24'd2)) && n < 20) begin step(); n++; end
    chk("t5_at_addr2", 128'(a_addr), 128'd2);
    chk("t5_no_restart", 128'(wr_cnt_a), 128'd2);
    chk("t5_busy", 128'(a_busy), 128'd1);
    reset_n = 1'b0;
    step();
    chk("t5_rst_en", 128'(a_en), 128'd0);
    chk("t5_rst_wcyc", 128'(a_wcyc), 128'd0);
    chk("t5_rst_busy", 128'(a_busy), 128'd0);
    chk("t5_rst_wr", 128'(a_wr), 128'd0);
    start_a = 1'b0;
    reset_n = 1'b1;
    step();
    chk("t5_idle", 128'(a_busy), 128'd0);
    pulse_start_a();
    chk("t5_addr0", 128'(a_addr), 128'd0);
    run_a("t5");
    chk("t5_pass", 128'(a_pass), 128'd1);
    chk("t5_writes", 128'(wr_cnt_a), 128'd4);
    chk("t5_reads", 128'(rd_cnt_a), 128'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
